// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared constants and types for the whack-a-mole button path
package whack_pkg;

  localparam int N_BUTTONS               = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_HOLD_CYCLES     = 100_000_000;

  localparam int BTN_MODE0 = 0;
  localparam int BTN_MODE1 = 1;
  localparam int BTN_MODE2 = 2;
  localparam int BTN_START = 3;

  // Bit 1 of the encoding is the debounced level, so the level needs no extra flop.
  typedef enum logic [1:0] {
    IDLE_LOW    = 2'b00,
    ARMING_HIGH = 2'b01,
    HELD_HIGH   = 2'b11,
    ARMING_LOW  = 2'b10
  } chan_state_e;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, debounce FSM, hold counter, pulse flops
module debounce_channel
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  logic          sync1_q, sync2_q;
  chan_state_e   state_q, state_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          hold_q, hold_d;
  logic          level_q;

  assign level_q = state_q[1];

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= IDLE_LOW;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    hold_d     = 1'b0;

    if (sync2_q == level_q) begin
      db_cnt_d = '0;
      state_d  = level_q ? HELD_HIGH : IDLE_LOW;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d  = '0;
      state_d   = level_q ? IDLE_LOW : HELD_HIGH;
      press_d   = !level_q;
      release_d = level_q;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
      state_d  = level_q ? ARMING_LOW : ARMING_HIGH;
    end

    // Saturating at HOLD_MAX is what limits hold_o to one pulse per press.
    if (!level_q) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end
    hold_d = level_q && (hold_cnt_q == HOLD_LAST);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button debounce and press/release/hold pulse generation
module button_conditioner #(
  parameter int N_BUTTONS       = whack_pkg::N_BUTTONS,
  parameter int DEBOUNCE_CYCLES = whack_pkg::DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = whack_pkg::DEFAULT_HOLD_CYCLES
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [N_BUTTONS-1:0] buttons_raw_i,
  output logic [N_BUTTONS-1:0] buttons_level_o,
  output logic [N_BUTTONS-1:0] press_o,
  output logic [N_BUTTONS-1:0] release_o,
  output logic [N_BUTTONS-1:0] hold_o,
  output logic                 any_press_o
);

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .raw_i    (buttons_raw_i[g]),
      .level_o  (buttons_level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .hold_o   (hold_o[g])
    );
  end

  // OR of flop outputs only, so it lines up with press_o and has no path from the pins.
  assign any_press_o = |press_o;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

  localparam int NB  = 4;
  localparam int DB  = 4;
  localparam int HLD = 10;
  localparam int LAT = DB + 2;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_HOLD    = 2;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] raw;
  logic [NB-1:0] level, press, rel, hold;
  logic          any_press;

  int      cyc;
  int      checks;
  int      errors;
  ev_t     sb[$];
  logic [NB-1:0] exp_level;

  button_conditioner #(
    .N_BUTTONS      (NB),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HLD)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst_n),
    .buttons_raw_i  (raw),
    .buttons_level_o(level),
    .press_o        (press),
    .release_o      (rel),
    .hold_o         (hold),
    .any_press_o    (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int ch, input int at);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.ch   = ch;
    sb.push_back(e);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Pop every event due this cycle and compare the whole output word.
  always @(negedge clk) begin
    logic [NB-1:0] ep, er, eh;
    ep = '0;
    er = '0;
    eh = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        if (sb[i].cyc < cyc) check("overdue", sb[i].cyc, cyc);
        case (sb[i].kind)
          K_PRESS:   ep[sb[i].ch] = 1'b1;
          K_RELEASE: er[sb[i].ch] = 1'b1;
          default:   eh[sb[i].ch] = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    exp_level = (exp_level | ep) & ~er;
    check("press", press, ep);
    check("release", rel, er);
    check("hold", hold, eh);
    check("any_press", any_press, |ep);
    check("level", level, exp_level);
  end

  initial begin
    int t0;
    int tr;
    checks    = 0;
    errors    = 0;
    exp_level = '0;
    rst_n     = 1'b0;
    raw       = '0;
    edges(3);
    check("rst_level", level, 0);
    check("rst_press", press, 0);
    check("rst_hold", hold, 0);
    rst_n = 1'b1;
    edges(3);

    // clean press on ch0, one hold, then clean release
    t0 = cyc;
    raw[0] = 1'b1;
    expect_ev(K_PRESS, 0, t0 + LAT);
    expect_ev(K_HOLD, 0, t0 + LAT + HLD);
    edges(25);
    t0 = cyc;
    raw[0] = 1'b0;
    expect_ev(K_RELEASE, 0, t0 + LAT);
    edges(12);

    // glitches on ch1 shorter than the debounce window
    raw[1] = 1'b1;
    edges(3);
    raw[1] = 1'b0;
    edges(1);
    raw[1] = 1'b1;
    edges(3);
    raw[1] = 1'b0;
    edges(15);

    // ch2 released before its hold expires
    t0 = cyc;
    raw[2] = 1'b1;
    expect_ev(K_PRESS, 2, t0 + LAT);
    edges(8);
    t0 = cyc;
    raw[2] = 1'b0;
    expect_ev(K_RELEASE, 2, t0 + LAT);
    edges(20);

    // simultaneous press on ch0 and ch3
    t0 = cyc;
    raw = 4'b1001;
    expect_ev(K_PRESS, 0, t0 + LAT);
    expect_ev(K_PRESS, 3, t0 + LAT);
    expect_ev(K_HOLD, 0, t0 + LAT + HLD);
    expect_ev(K_HOLD, 3, t0 + LAT + HLD);
    edges(20);
    t0 = cyc;
    raw = 4'b0000;
    expect_ev(K_RELEASE, 0, t0 + LAT);
    expect_ev(K_RELEASE, 3, t0 + LAT);
    edges(12);

    // reset in the middle of a hold count, button kept down across it
    t0 = cyc;
    raw[0] = 1'b1;
    expect_ev(K_PRESS, 0, t0 + LAT);
    expect_ev(K_HOLD, 0, t0 + LAT + HLD);
    edges(12);
    check("pre_rst_level", level, 4'b0001);
    rst_n = 1'b0;
    sb.delete();
    exp_level = '0;
    #1;
    check("mid_rst_level", level, 0);
    check("mid_rst_press", press, 0);
    check("mid_rst_release", rel, 0);
    check("mid_rst_hold", hold, 0);
    check("mid_rst_any", any_press, 0);
    edges(8);
    tr = cyc;
    rst_n = 1'b1;
    expect_ev(K_PRESS, 0, tr + LAT);
    expect_ev(K_HOLD, 0, tr + LAT + HLD);
    edges(20);

    // contact bounce while ch0 is high: 2-cycle lows never release it
    for (int i = 0; i < 10; i++) begin
      raw[0] = i[0];
      edges(2);
    end
    check("bounce_level", level, 4'b0001);
    t0 = cyc;
    raw[0] = 1'b0;
    expect_ev(K_RELEASE, 0, t0 + LAT);
    edges(15);

    check("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw push-button inputs of the whack-a-mole design before they reach mode selection and reset handling. Each button is synchronised into the clock domain, debounced with a per-button counter, and turned into a clean level plus single-cycle press, release and long-hold pulses. It sits directly upstream of the mode-selection and reset-handling logic and replaces the raw `buttons_i` feeding them.

## Interface
- `N_BUTTONS`, 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive clock cycles a synchronised input must differ from the stable level before the level flips (10 ms at 100 MHz). Must be ≥ 1.
- `HOLD_CYCLES`, 100_000_000: cycles a debounced level must stay high before `hold_o` fires (1 s at 100 MHz). Must be ≥ 1.

- `clock_i`  in  1  system clock; all state on the rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `buttons_raw_i`  in  N_BUTTONS  raw asynchronous button pins, active-high.
- `buttons_level_o`  out  N_BUTTONS  debounced button level.
- `press_o`  out  N_BUTTONS  one-cycle pulse on each debounced 0→1 transition.
- `release_o`  out  N_BUTTONS  one-cycle pulse on each debounced 1→0 transition.
- `hold_o`  out  N_BUTTONS  one-cycle pulse once per press, after the level has been high for `HOLD_CYCLES`.
- `any_press_o`  out  1  OR of `press_o`.

## Operation
- Each channel runs independently and identically.
- **Synchroniser:** two flops per channel (`sync1` → `sync2`). Only `sync2` is used downstream.
- **Debounce counter:** width `$clog2(DEBOUNCE_CYCLES+1)`.
  - When `sync2 == level`: the counter clears to 0.
  - When `sync2 != level` and `count < DEBOUNCE_CYCLES-1`: the counter increments.
  - When `sync2 != level` and `count == DEBOUNCE_CYCLES-1`: `level` inverts and the counter clears.
- **Glitches:** any return of `sync2` to `level` before expiry clears the counter. A glitch shorter than `DEBOUNCE_CYCLES` never changes `level`.
- **Press/release pulses:** `press_o` and `release_o` are registered at the same edge that flips `level`. They are high for exactly one cycle, in the same cycle `buttons_level_o` first shows the new value.
- **Hold counter:** width `$clog2(HOLD_CYCLES+1)`.
  - Clears while `level == 0`.
  - Increments while `level == 1`, saturating at `HOLD_CYCLES`.
  - `hold_o` pulses on the edge where the counter goes from `HOLD_CYCLES-1` to `HOLD_CYCLES`.
  - A continuously held button produces exactly one `hold_o`.
- **Per-channel state** (implicit in `level` and the counters): IDLE_LOW, ARMING_HIGH (counting to press), HELD_HIGH, ARMING_LOW (counting to release).
- **Simultaneous events:** several channels may pulse in the same cycle. `any_press_o` is the OR of the channel pulses. Channels never block each other.

## Timing
- **Reset values:** `sync1`, `sync2`, `level`, both counters, and every output are 0 while `reset_i` is low.
- **Press latency:** take the first rising edge that samples `buttons_raw_i` high as edge 1. `buttons_level_o` and `press_o` assert at edge `DEBOUNCE_CYCLES+2`, provided raw stays high throughout. Release latency is identical.
- **Hold latency:** `hold_o` asserts `HOLD_CYCLES` edges after the edge that asserted `press_o`.
- **Reset mid-operation:** all state clears immediately and pending pulses are dropped.
  - A button still held when reset deasserts produces `press_o` after the full press latency, counted from the first post-reset edge.
  - It then produces `hold_o` `HOLD_CYCLES` later.
- **Release during hold count:** if `level` falls before the hold count expires, the hold counter clears and no `hold_o` is issued for that press.
- **Outputs:** all outputs are registered. There is no combinational path from input to output.

## Structure
- **Shared package `whack_pkg`:**
  - `N_BUTTONS`.
  - Default `DEBOUNCE_CYCLES` and `HOLD_CYCLES` constants.
  - Button index constants (mode-select buttons 0–2, start/reset button 3).
- **Sub-module `debounce_channel`:** one channel (synchroniser, debounce counter, hold counter, pulse flops).
- **Top wrapper:** instantiates `N_BUTTONS` copies via generate and ORs `press_o` into `any_press_o`.

## Test plan
Parameters `DEBOUNCE_CYCLES=4` and `HOLD_CYCLES=10` apply to every scenario.
- **Clean press:** raise `buttons_raw_i[0]` and hold; take edge 1 as the first edge that samples it high. Required: level[0] and `press_o[0]` rise at edge 6; `press_o[0]` is low at edge 7; `hold_o[0]` pulses once at edge 16 and never again.
- **Glitch rejection:** pulse raw[1] high for 3 cycles, low for 1, then high for 3. Required: `buttons_level_o[1]` stays 0 and no `press_o` fires.
- **Release:** from held-high, drop raw[2]. Required: level[2] falls and `release_o[2]` pulses exactly 6 edges later. If the drop happens before hold expiry, no `hold_o[2]` fires.
- **Simultaneous:** raise raw[0] and raw[3] on the same edge. Required: `press_o` = 4'b1001 and `any_press_o` = 1 in the same cycle, at edge 6.
- **Reset mid-hold:** hold raw[0], then assert `reset_i` low at edge 12. Required: all outputs are 0 immediately. After reset is released at edge 20, `press_o[0]` pulses 6 edges later and `hold_o[0]` pulses 10 edges after that.
- **Bounce on release:** toggle raw[0] every 2 cycles for 20 cycles while level is 1. Required: level holds at 1 and no `release_o` fires until raw is stable low for 4 cycles.
